fetch_stage: RTL
================

Name: fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline: PC register, next-PC selection, instruction-memory request, and the F/D pipeline register.
- Directly upstream of the decode controller. Consumes its redirect decision (pc_sel, is_j, is_b) plus the jr operand, and feeds it D_IR/D_PC.
- Branch delay slot architecture: redirects apply after the delay-slot fetch, so no flush is needed.
- Tolerates instruction-memory wait states by inserting bubbles and remembering a redirect that arrives during a wait.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- IM_BYTES, 16384, instruction memory size in bytes (used only by the optional feature).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hazard-unit freeze of PC, F/D register and pending-redirect state.
- pc_sel  in  2  decode redirect select: 0 = PC+4, 1 = NPC, 2 = JRPC.
- is_j  in  1  decode: unconditional j/jal.
- is_b  in  1  decode: branch condition true.
- rs_val  in  32  forwarded GPR[rs] for jr.
- imem_ready  in  1  imem_rdata valid for imem_addr this cycle.
- imem_rdata  in  32  instruction word.
- imem_addr  out  32  current PC (registered).
- D_IR  out  32  instruction in decode.
- D_PC  out  32  PC of D_IR.
- D_PC8  out  32  D_PC+8, the jal link value (combinational from D_PC).
- D_valid  out  1  D_IR is a real instruction, not a bubble.
- D_exc_adel  out  1  fetch address error (optional feature; tied 0 when not compiled in).

Behaviour:
- Reset, asynchronous on reset low:
  - PC = RESET_PC.
  - D_IR = 0, D_PC = 0, D_valid = 0, D_exc_adel = 0.
  - pend_valid = 0, pend_pc = 0.
- imem_addr = PC, with no combinational path from inputs.
- Redirect (combinational):
  - redir = D_valid & ((pc_sel==1 & (is_j|is_b)) | pc_sel==2).
  - pc_sel==1 with is_j=is_b=0 (beq not taken) is not a redirect.
- Target (combinational, from D_IR and D_PC):
  - pc_sel==2: rs_val.
  - pc_sel==1 & is_j: {D_PC[31:28]+carry-free of D_PC+4, D_IR[25:0], 2'b00}, i.e. upper nibble taken from D_PC+4.
  - pc_sel==1 & is_b: D_PC + 4 + (sign_ext(D_IR[15:0]) << 2), with 32-bit wrap.
- Per cycle, in priority order:
  1. stall=1: hold PC, F/D and pend. Stall dominates imem_ready and redir; decode re-presents the decision next cycle.
  2. stall=0 & imem_ready=1 (fire):
     - F/D <= {imem_rdata, PC, valid=1}.
     - PC <= redir ? target : pend_valid ? pend_pc : PC+4.
     - pend_valid <= 0.
  3. stall=0 & imem_ready=0 (wait):
     - F/D <= bubble {IR=0, PC=0, valid=0}; PC held.
     - If redir: pend_pc <= target, pend_valid <= 1.
- redir and pend_valid cannot both be true, because D holds a bubble while pend_valid is set. If they coincide anyway, redir wins.
- PC+4 wraps modulo 2^32.
- The delay-slot instruction is always the one fetched at the PC current when the redirect was seen.
- No state machine beyond the pend register; the two-state machine is {IDLE, PEND}, encoded by pend_valid.

Optional Feature:
- Macro: FETCH_ADEL_EN.
- With the macro, on fire, fault = PC[1:0]!=0 | PC<RESET_PC | PC>=RESET_PC+IM_BYTES. If fault:
  - D_IR <= 0 (nop), D_valid <= 1, D_exc_adel <= 1, and imem_rdata is ignored.
  - imem_ready is still required, so the faulting fetch is not issued speculatively.
  - The PC update follows the normal fire rule.
- Without the macro: no range/alignment check; D_exc_adel is constant 0.

Decomposition:
- Shared package/header holds:
  - PC select codes PC4/NPC/JRPC.
  - Instruction field ranges (OP, IMM16, INSTR_INDEX).
  - NOP encoding and RESET_PC default.
- One sub-module: npc_calc. Purely combinational; computes target and redir from pc_sel/is_j/is_b/D_IR/D_PC/rs_val. It is reused by any later branch-resolution changes.

Test Plan:
- Reset release with imem_ready=1, stall=0:
  - imem_addr=0x3000 and D_valid=0.
  - After 1 edge: D_PC=0x3000, imem_addr=0x3004.
  - After 2 edges: D_PC=0x3004.
- Taken beq: D_IR=0x1000_0003 at D_PC=0x3000 with pc_sel=1, is_b=1 (F fetching 0x3004) -> next imem_addr=0x3010, D_PC=0x3004.
- jal: D_IR=0x0C00_0C10 at D_PC=0x3008 with pc_sel=1, is_j=1 -> next imem_addr=0x0000_3040, D_PC8=0x3010.
- stall=1 for 2 cycles mid-stream with redir asserted -> imem_addr, D_IR, D_PC unchanged. After release, redirect is taken exactly once.
- Wait-state redirect:
  - imem_ready=0 while D holds j 0x0800_0C20 at 0x3000 -> D_valid=0 next cycle, imem_addr stays 0x3004.
  - imem_ready=1 -> D_PC=0x3004, then imem_addr=0x3080.
- FETCH_ADEL_EN, jr with rs_val=0x3002 -> after the delay slot, D_exc_adel=1, D_IR=0, D_valid=1, D_PC=0x3002. Without the macro, D_exc_adel stays 0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the IF stage: redirect select codes, instruction
// field ranges, the NOP encoding and the default reset PC.
package fetch_stage_pkg;

  // Decode redirect select codes
  localparam logic [1:0] PC_SEL_PC4  = 2'd0;
  localparam logic [1:0] PC_SEL_NPC  = 2'd1;
  localparam logic [1:0] PC_SEL_JRPC = 2'd2;

  // Instruction field ranges
  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int IMM16_MSB = 15;
  localparam int IMM16_LSB = 0;
  localparam int INDEX_MSB = 25;
  localparam int INDEX_LSB = 0;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // Sign-extend a 16-bit immediate to 32 bits
  function automatic logic [31:0] sext_imm16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/fetch_stage_npc_calc.sv
// npc_calc: combinational redirect decision and target for the instruction
// currently in decode. Only the low 26 instruction bits matter here (jump
// index, which also contains the branch offset).
module npc_calc
  import fetch_stage_pkg::*;
(
  input  logic        d_valid,
  input  logic [1:0]  pc_sel,
  input  logic        is_j,
  input  logic        is_b,
  input  logic [25:0] instr_index,
  input  logic [31:0] d_pc,
  input  logic [31:0] rs_val,
  output logic [31:0] target,
  output logic        redir
);

  logic [31:0] pc4_s;

  // Select the redirect target; a bubble in decode never redirects
  always_comb begin
    pc4_s  = d_pc + 32'd4;
    target = pc4_s;
    redir  = 1'b0;
    case (pc_sel)
      PC_SEL_JRPC: begin
        target = rs_val;
        redir  = d_valid;
      end
      PC_SEL_NPC: begin
        if (is_j) begin
          // Region (upper nibble) comes from the delay-slot address
          target = {pc4_s[31:28], instr_index[INDEX_MSB:INDEX_LSB], 2'b00};
          redir  = d_valid;
        end else if (is_b) begin
          target = pc4_s + (sext_imm16(instr_index[IMM16_MSB:IMM16_LSB]) << 5'd2);
          redir  = d_valid;
        end else begin
          // Branch not taken: sequential fetch continues
          target = pc4_s;
          redir  = 1'b0;
        end
      end
      default: begin
        target = pc4_s;
        redir  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage with PC register, next-PC selection, imem
// request and F/D pipeline register. Redirects take effect after the delay
// slot; a redirect seen while imem is waiting is held in a pending register.
// Optional fetch address-error check is compiled in with FETCH_ADEL_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned IM_BYTES = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  pc_sel,
  input  logic        is_j,
  input  logic        is_b,
  input  logic [31:0] rs_val,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] D_IR,
  output logic [31:0] D_PC,
  output logic [31:0] D_PC8,
  output logic        D_valid,
  output logic        D_exc_adel
);

  logic [31:0] pc_r, pc_nxt_s;
  logic [31:0] d_ir_r, d_ir_nxt_s;
  logic [31:0] d_pc_r, d_pc_nxt_s;
  logic        d_valid_r, d_valid_nxt_s;
  logic        d_exc_r, d_exc_nxt_s;
  logic        pend_valid_r, pend_valid_nxt_s;
  logic [31:0] pend_pc_r, pend_pc_nxt_s;
  logic [31:0] target_s;
  logic        redir_s;
  logic        fault_s;

  npc_calc u_npc_calc (
    .d_valid     (d_valid_r),
    .pc_sel      (pc_sel),
    .is_j        (is_j),
    .is_b        (is_b),
    .instr_index (d_ir_r[INDEX_MSB:INDEX_LSB]),
    .d_pc        (d_pc_r),
    .rs_val      (rs_val),
    .target      (target_s),
    .redir       (redir_s)
  );

`ifdef FETCH_ADEL_EN
  localparam logic [32:0] IM_LIMIT = {1'b0, RESET_PC} + 33'(IM_BYTES);

  // Misaligned or out-of-image fetch address
  always_comb begin
    fault_s = (pc_r[1:0] != 2'b00) | (pc_r < RESET_PC) | ({1'b0, pc_r} >= IM_LIMIT);
  end
`else
  // Image size only matters for the address check, which is not built here
  logic [31:0] unused_im_bytes_s;
  assign unused_im_bytes_s = IM_BYTES;
  assign fault_s           = 1'b0;
`endif

  // Next PC, F/D contents and pending redirect: stall > fire > wait
  always_comb begin
    pc_nxt_s         = pc_r;
    d_ir_nxt_s       = d_ir_r;
    d_pc_nxt_s       = d_pc_r;
    d_valid_nxt_s    = d_valid_r;
    d_exc_nxt_s      = d_exc_r;
    pend_valid_nxt_s = pend_valid_r;
    pend_pc_nxt_s    = pend_pc_r;
    if (stall) begin
      pc_nxt_s = pc_r;
    end else if (imem_ready) begin
      d_ir_nxt_s       = fault_s ? NOP_INSTR : imem_rdata;
      d_pc_nxt_s       = pc_r;
      d_valid_nxt_s    = 1'b1;
      d_exc_nxt_s      = fault_s;
      pend_valid_nxt_s = 1'b0;
      if (redir_s) begin
        pc_nxt_s = target_s;
      end else if (pend_valid_r) begin
        pc_nxt_s = pend_pc_r;
      end else begin
        pc_nxt_s = pc_r + 32'd4;
      end
    end else begin
      d_ir_nxt_s    = NOP_INSTR;
      d_pc_nxt_s    = 32'h0000_0000;
      d_valid_nxt_s = 1'b0;
      d_exc_nxt_s   = 1'b0;
      if (redir_s) begin
        pend_pc_nxt_s    = target_s;
        pend_valid_nxt_s = 1'b1;
      end else begin
        pend_pc_nxt_s    = pend_pc_r;
        pend_valid_nxt_s = pend_valid_r;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r         <= RESET_PC;
      d_ir_r       <= 32'h0000_0000;
      d_pc_r       <= 32'h0000_0000;
      d_valid_r    <= 1'b0;
      d_exc_r      <= 1'b0;
      pend_valid_r <= 1'b0;
      pend_pc_r    <= 32'h0000_0000;
    end else begin
      pc_r         <= pc_nxt_s;
      d_ir_r       <= d_ir_nxt_s;
      d_pc_r       <= d_pc_nxt_s;
      d_valid_r    <= d_valid_nxt_s;
      d_exc_r      <= d_exc_nxt_s;
      pend_valid_r <= pend_valid_nxt_s;
      pend_pc_r    <= pend_pc_nxt_s;
    end
  end

  assign imem_addr  = pc_r;
  assign D_IR       = d_ir_r;
  assign D_PC       = d_pc_r;
  assign D_PC8      = d_pc_r + 32'd8;
  assign D_valid    = d_valid_r;
  assign D_exc_adel = d_exc_r;

endmodule
